riscv_trace_buffer: RTL

Commit-trace capture stage directly downstream of the `riscv` core top. It samples the core's per-cycle register-write and data-memory observation ports and converts each retired effect into a timestamped trace entry. Entries are buffered in a dual-push FIFO and drained over a valid/ready stream to a testbench monitor or debug link. Overflow is counted, never stalls the core.

---
 rtl/riscv_trace_pkg.sv | 24 ++
 rtl/riscv_trace_buffer_fifo.sv | 63 ++++++
 rtl/riscv_trace_buffer.sv | 81 ++++++++
 3 files changed

// File: rtl/riscv_trace_pkg.sv
// Shared types for the commit-trace capture stage: event kinds and the packed
// trace entry layout {ts, kind, tag, data}.
package riscv_trace_pkg;

  localparam int TRACE_TS_W   = 16;
  localparam int TRACE_TAG_W  = 9;
  localparam int TRACE_DATA_W = 32;

  typedef enum logic [1:0] {
    KIND_REG   = 2'b01,
    KIND_STORE = 2'b10,
    KIND_LOAD  = 2'b11
  } trace_kind_e;

  typedef struct packed {
    logic [TRACE_TS_W-1:0]   ts;
    trace_kind_e             kind;
    logic [TRACE_TAG_W-1:0]  tag;
    logic [TRACE_DATA_W-1:0] data;
  } trace_entry_t;

  localparam int TRACE_ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/riscv_trace_buffer_fifo.sv
// Dual-push, single-pop first-word-fall-through FIFO. Pushes are admitted
// all-or-nothing against the registered occupancy (a same-cycle pop frees nothing).
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 59
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push0,
  input  logic [W-1:0]             data0,
  input  logic                     push1,
  input  logic [W-1:0]             data1,
  input  logic                     ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     rejected
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [LW-1:0] n;
  logic [LW-1:0] free;
  logic          accept;
  logic          pop;

  // push1 is only ever raised together with push0, so slot order is push0 first.
  assign n        = LW'(push0) + LW'(push1);
  assign free     = LW'(DEPTH) - level_q;
  assign accept   = (n != '0) && (n <= free);
  assign rejected = (n != '0) && !accept;
  assign pop      = out_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(n);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_q + (accept ? n : '0) - LW'(pop);
    end
  end

  // Storage is not reset: out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= data0;
      if (push1) mem[wr_ptr + AW'(1)] <= data1;
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign level     = level_q;

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture: decodes register-write and data-memory observations into
// timestamped entries, buffers them, and counts (never stalls on) overflow.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trace_en,
  input  logic                    reg_write_sig,
  input  logic [4:0]              reg_num,
  input  logic [31:0]             reg_data,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [8:0]              addr,
  input  logic [31:0]             wr_data,
  input  logic [31:0]             rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [43+TS_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [15:0]             drop_count
);

  // Output stream: the head entry transfers on any cycle where out_valid && out_ready;
  // out_data holds steady while out_valid is high and out_ready is low.

  localparam int EW = 43 + TS_W;

  logic [TS_W-1:0] ts;
  logic            mem_ev;
  logic            reg_ev;
  trace_kind_e     mem_kind;
  logic [EW-1:0]   mem_entry;
  logic [EW-1:0]   reg_entry;
  logic            push0;
  logic            push1;
  logic            rejected;

  assign mem_ev    = trace_en && (wr || rd);
  assign reg_ev    = trace_en && reg_write_sig && (reg_num != 5'd0);
  assign mem_kind  = wr ? KIND_STORE : KIND_LOAD;
  assign mem_entry = {ts, mem_kind, addr, (wr ? wr_data : rd_data)};
  assign reg_entry = {ts, KIND_REG, 4'b0000, reg_num, reg_data};

  // Memory event goes first so a load's writeback follows the load itself.
  assign push0 = mem_ev || reg_ev;
  assign push1 = mem_ev && reg_ev;

  trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push0     (push0),
    .data0     (mem_ev ? mem_entry : reg_entry),
    .push1     (push1),
    .data1     (reg_entry),
    .ready     (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .rejected  (rejected)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts         <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (rejected) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule
